// File: rtl/plank_ctrl.sv
// plank_ctrl: UART-programmed beam-steering controller for an 8-channel T/R plank.
// A 21-byte frame (0xAA, mask, 8x attn, 8x phase, ctrl, XOR checksum, 0x55)
// updates the live channel registers.  The override inputs act on the registered outputs.
// Optional build macro: PLANK_TX_ACK_EN sends an ACK (0x06) or NAK (0x15) byte after each frame.
module plank_ctrl #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_serial,
  input  logic       i_inhibit,
  input  logic       i_TR_pulse,
  input  logic       i_attn_31p5,
  input  logic       i_phase_180,
  output logic       o_tx_serial,
  output logic [7:0] o_ch_power,
  output logic [5:0] o_attn_ch1,
  output logic [5:0] o_attn_ch2,
  output logic [5:0] o_attn_ch3,
  output logic [5:0] o_attn_ch4,
  output logic [5:0] o_attn_ch5,
  output logic [5:0] o_attn_ch6,
  output logic [5:0] o_attn_ch7,
  output logic [5:0] o_attn_ch8,
  output logic [5:0] o_phase_ch1,
  output logic [5:0] o_phase_ch2,
  output logic [5:0] o_phase_ch3,
  output logic [5:0] o_phase_ch4,
  output logic [5:0] o_phase_ch5,
  output logic [5:0] o_phase_ch6,
  output logic [5:0] o_phase_ch7,
  output logic [5:0] o_phase_ch8,
  output logic       o_TR_Pulse,
  inout  wire        io_scl,
  inout  wire        io_sda
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int TO_W  = $clog2(32 * CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TO_W-1:0]  TO_RELOAD   = TO_W'(32 * CLKS_PER_BIT - 1);

  // The I2C bus is reserved, so both lines are always released.
  assign io_scl = 1'bz;
  assign io_sda = 1'bz;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_WAIT_HDR, P_PAYLOAD, P_CHECK, P_FOOTER} p_state_t;

  logic [1:0]       rx_sync_q;
  logic             rx_prev_q;
  rx_state_t        rx_state_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_idx_q;
  logic [7:0]       rx_shift_q;
  logic [7:0]       rx_byte_q;
  logic             rx_valid_q;
  logic             rx_bit;

  // Override synchronizers: bit0 inhibit, bit1 attn_31p5, bit2 phase_180, bit3 TR pulse.
  logic [3:0]       ovr_s1_q;
  logic [3:0]       ovr_s2_q;

  p_state_t         p_state_q;
  logic [4:0]       idx_q;
  logic [7:0]       xor_q;
  logic             cks_ok_q;
  logic [7:0]       shadow_q [18];
  logic [TO_W-1:0]  to_cnt_q;

  logic [7:0]       power_q;
  logic [5:0]       attn_q [8];
  logic [5:0]       phase_q [8];
  logic             tr_en_q;

  logic [7:0]       out_power_q;
  logic [5:0]       out_attn_q [8];
  logic [5:0]       out_phase_q [8];
  logic             out_tr_q;

`ifdef PLANK_TX_ACK_EN
  logic             verdict_q;
  logic             verdict_ack_q;
`endif

  assign rx_bit = rx_sync_q[1];

  // Two-stage synchronizers for the serial line and the override inputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_sync_q <= 2'b11;
      ovr_s1_q  <= 4'b0000;
      ovr_s2_q  <= 4'b0000;
    end else begin
      rx_sync_q <= {rx_sync_q[0], i_rx_serial};
      ovr_s1_q  <= {i_TR_pulse, i_phase_180, i_attn_31p5, i_inhibit};
      ovr_s2_q  <= ovr_s1_q;
    end
  end

  // UART receiver: falling-edge start, mid-bit sampling, and a low stop bit drops the byte.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_state_q <= RX_IDLE;
      rx_prev_q  <= 1'b1;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_prev_q  <= rx_bit;
      rx_valid_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_bit) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= HALF_RELOAD;
          end
        end
        RX_START: begin
          if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end else if (!rx_bit) begin
            rx_state_q <= RX_DATA;
            rx_cnt_q   <= BIT_RELOAD;
            rx_idx_q   <= '0;
          end else begin
            rx_state_q <= RX_IDLE;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end else begin
            rx_shift_q <= {rx_bit, rx_shift_q[7:1]};
            rx_cnt_q   <= BIT_RELOAD;
            if (rx_idx_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_idx_q   <= rx_idx_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end else begin
            if (rx_bit) begin
              rx_byte_q  <= rx_shift_q;
              rx_valid_q <= 1'b1;
            end
            rx_state_q <= RX_IDLE;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Frame parser: header hunt, shadow capture, checksum and footer check, atomic commit, and timeout.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      p_state_q <= P_WAIT_HDR;
      idx_q     <= '0;
      xor_q     <= '0;
      cks_ok_q  <= 1'b0;
      to_cnt_q  <= TO_RELOAD;
      power_q   <= '0;
      tr_en_q   <= 1'b0;
      for (int i = 0; i < 18; i++) shadow_q[5'(i)] <= '0;
      for (int i = 0; i < 8; i++) begin
        attn_q[3'(i)]  <= 6'h3F;
        phase_q[3'(i)] <= '0;
      end
`ifdef PLANK_TX_ACK_EN
      verdict_q     <= 1'b0;
      verdict_ack_q <= 1'b0;
`endif
    end else begin
`ifdef PLANK_TX_ACK_EN
      verdict_q <= 1'b0;
`endif
      if (p_state_q == P_WAIT_HDR || rx_valid_q) to_cnt_q <= TO_RELOAD;
      else if (to_cnt_q != '0)                   to_cnt_q <= to_cnt_q - 1'b1;

      if (p_state_q != P_WAIT_HDR && !rx_valid_q && to_cnt_q == '0) begin
        p_state_q <= P_WAIT_HDR;
      end else if (rx_valid_q) begin
        case (p_state_q)
          P_WAIT_HDR: begin
            if (rx_byte_q == 8'hAA) begin
              p_state_q <= P_PAYLOAD;
              idx_q     <= '0;
              xor_q     <= '0;
            end
          end
          P_PAYLOAD: begin
            shadow_q[idx_q] <= rx_byte_q;
            xor_q           <= xor_q ^ rx_byte_q;
            if (idx_q == 5'd17) p_state_q <= P_CHECK;
            else                idx_q     <= idx_q + 1'b1;
          end
          P_CHECK: begin
            cks_ok_q  <= (rx_byte_q == xor_q);
            p_state_q <= P_FOOTER;
          end
          P_FOOTER: begin
            if (cks_ok_q && rx_byte_q == 8'h55) begin
              power_q <= shadow_q[0];
              tr_en_q <= shadow_q[17][0];
              for (int i = 0; i < 8; i++) begin
                attn_q[3'(i)]  <= shadow_q[5'(i + 1)][5:0];
                phase_q[3'(i)] <= shadow_q[5'(i + 9)][5:0];
              end
            end
`ifdef PLANK_TX_ACK_EN
            verdict_q     <= 1'b1;
            verdict_ack_q <= cks_ok_q && (rx_byte_q == 8'h55);
`endif
            p_state_q <= P_WAIT_HDR;
          end
          default: p_state_q <= P_WAIT_HDR;
        endcase
      end
    end
  end

  // Registered output stage that combines the live registers with the synchronized overrides.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_power_q <= '0;
      out_tr_q    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        out_attn_q[3'(i)]  <= 6'h3F;
        out_phase_q[3'(i)] <= '0;
      end
    end else begin
      out_power_q <= ovr_s2_q[0] ? 8'h00 : power_q;
      out_tr_q    <= ovr_s2_q[3] & tr_en_q & ~ovr_s2_q[0];
      for (int i = 0; i < 8; i++) begin
        out_attn_q[3'(i)]  <= ovr_s2_q[1] ? 6'h3F : attn_q[3'(i)];
        out_phase_q[3'(i)] <= phase_q[3'(i)] + {ovr_s2_q[2], 5'b00000};
      end
    end
  end

  assign o_ch_power  = out_power_q;
  assign o_TR_Pulse  = out_tr_q;
  assign o_attn_ch1  = out_attn_q[0];
  assign o_attn_ch2  = out_attn_q[1];
  assign o_attn_ch3  = out_attn_q[2];
  assign o_attn_ch4  = out_attn_q[3];
  assign o_attn_ch5  = out_attn_q[4];
  assign o_attn_ch6  = out_attn_q[5];
  assign o_attn_ch7  = out_attn_q[6];
  assign o_attn_ch8  = out_attn_q[7];
  assign o_phase_ch1 = out_phase_q[0];
  assign o_phase_ch2 = out_phase_q[1];
  assign o_phase_ch3 = out_phase_q[2];
  assign o_phase_ch4 = out_phase_q[3];
  assign o_phase_ch5 = out_phase_q[4];
  assign o_phase_ch6 = out_phase_q[5];
  assign o_phase_ch7 = out_phase_q[6];
  assign o_phase_ch8 = out_phase_q[7];

`ifdef PLANK_TX_ACK_EN
  logic             tx_q;
  logic             tx_busy_q;
  logic [8:0]       tx_shift_q;
  logic [3:0]       tx_bits_q;
  logic [CNT_W-1:0] tx_cnt_q;

  // ACK/NAK transmitter.  A verdict that arrives while a byte is in flight is dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_shift_q <= '0;
      tx_bits_q  <= '0;
      tx_cnt_q   <= '0;
    end else if (!tx_busy_q) begin
      if (verdict_q) begin
        tx_shift_q <= {1'b1, (verdict_ack_q ? 8'h06 : 8'h15)};
        tx_q       <= 1'b0;
        tx_busy_q  <= 1'b1;
        tx_bits_q  <= 4'd9;
        tx_cnt_q   <= BIT_RELOAD;
      end
    end else if (tx_cnt_q != '0) begin
      tx_cnt_q <= tx_cnt_q - 1'b1;
    end else if (tx_bits_q == 4'd0) begin
      tx_busy_q <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      tx_q       <= tx_shift_q[0];
      tx_shift_q <= {1'b0, tx_shift_q[8:1]};
      tx_bits_q  <= tx_bits_q - 1'b1;
      tx_cnt_q   <= BIT_RELOAD;
    end
  end

  assign o_tx_serial = tx_q;
`else
  assign o_tx_serial = 1'b1;
`endif

endmodule

// File: tb/tb_plank_ctrl.sv
// Testbench for plank_ctrl: directed test-plan steps followed by randomized frames,
// checked against a frame-level reference model.
module tb_plank_ctrl;
  localparam int BIT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1, inh = 1'b0, trp = 1'b0, a31 = 1'b0, p180 = 1'b0;
  wire  tx;
  logic [7:0] pwr;
  logic [5:0] attn_o [8];
  logic [5:0] phase_o [8];
  logic tro;
  wire  scl, sda;

  always #5 clk = ~clk;

  plank_ctrl #(.CLKS_PER_BIT(BIT)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_serial(rx), .i_inhibit(inh), .i_TR_pulse(trp),
    .i_attn_31p5(a31), .i_phase_180(p180), .o_tx_serial(tx), .o_ch_power(pwr),
    .o_attn_ch1(attn_o[0]), .o_attn_ch2(attn_o[1]), .o_attn_ch3(attn_o[2]), .o_attn_ch4(attn_o[3]),
    .o_attn_ch5(attn_o[4]), .o_attn_ch6(attn_o[5]), .o_attn_ch7(attn_o[6]), .o_attn_ch8(attn_o[7]),
    .o_phase_ch1(phase_o[0]), .o_phase_ch2(phase_o[1]), .o_phase_ch3(phase_o[2]), .o_phase_ch4(phase_o[3]),
    .o_phase_ch5(phase_o[4]), .o_phase_ch6(phase_o[5]), .o_phase_ch7(phase_o[6]), .o_phase_ch8(phase_o[7]),
    .o_TR_Pulse(tro), .io_scl(scl), .io_sda(sda)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: what the live registers should hold.
  logic [7:0] m_power;
  logic [5:0] m_attn [8];
  logic [5:0] m_phase [8];
  logic       m_tr;
  logic [7:0] frm [21];
  logic [7:0] tx_seen [$];
  logic [7:0] tx_exp [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_power = 8'h00;
    m_tr    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_attn[i]  = 6'h3F;
      m_phase[i] = 6'h00;
    end
  endtask

  task automatic check_all(input string tag);
    int ph;
    @(negedge clk);
    chk({tag, "_pwr"}, pwr, inh ? 8'h00 : m_power);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_attn%0d", tag, i + 1), attn_o[i], a31 ? 6'h3F : m_attn[i]);
      ph = (int'(m_phase[i]) + (p180 ? 32 : 0)) % 64;
      chk($sformatf("%s_phase%0d", tag, i + 1), attn_o[i] === attn_o[i] ? phase_o[i] : 6'h00, ph);
    end
    chk({tag, "_tr"}, tro, trp & m_tr & ~inh);
  endtask

  task automatic check_tx(input string tag);
    chk({tag, "_txcount"}, tx_seen.size(), tx_exp.size());
    while (tx_seen.size() > 0 && tx_exp.size() > 0)
      chk({tag, "_txbyte"}, tx_seen.pop_front(), tx_exp.pop_front());
    tx_seen.delete();
    tx_exp.delete();
    chk({tag, "_txidle"}, tx, 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx = 1'b0;
    repeat (BIT - 1) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); rx = b[k];
      repeat (BIT - 1) @(negedge clk);
    end
    @(negedge clk); rx = 1'b1;
    repeat (BIT - 1) @(negedge clk);
  endtask

  task automatic fill_frame(input logic [7:0] pm, input logic [7:0] v, input logic [7:0] ctrl);
    logic [7:0] x;
    frm[0] = 8'hAA;
    frm[1] = pm;
    for (int i = 2; i <= 17; i++) frm[i] = v;
    frm[18] = ctrl;
    x = 8'h00;
    for (int i = 1; i <= 18; i++) x ^= frm[i];
    frm[19] = x;
    frm[20] = 8'h55;
  endtask

  // Send frm, apply the frame rules to the model, let any response finish, then check.
  task automatic send_frame(input string tag);
    logic [7:0] x;
    for (int i = 0; i < 21; i++) send_byte(frm[i]);
    x = 8'h00;
    for (int i = 1; i <= 18; i++) x ^= frm[i];
    if (x == frm[19] && frm[20] == 8'h55) begin
      m_power = frm[1];
      for (int i = 0; i < 8; i++) begin
        m_attn[i]  = frm[2 + i][5:0];
        m_phase[i] = frm[10 + i][5:0];
      end
      m_tr = frm[18][0];
`ifdef PLANK_TX_ACK_EN
      tx_exp.push_back(8'h06);
`endif
    end else begin
`ifdef PLANK_TX_ACK_EN
      tx_exp.push_back(8'h15);
`endif
    end
    repeat (12 * BIT) @(negedge clk);
    check_all(tag);
    check_tx(tag);
  endtask

  // Background UART decoder for the response line.
  initial begin
    logic [7:0] b;
    @(negedge rst);
    forever begin
      @(negedge tx);
      repeat (BIT / 2) @(negedge clk);
      if (tx == 1'b0) begin
        for (int k = 0; k < 8; k++) begin
          repeat (BIT) @(negedge clk);
          b[k] = tx;
        end
        repeat (BIT) @(negedge clk);
        tx_seen.push_back(tx ? b : 8'h00);
      end
    end
  end

  initial begin
    model_reset();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    check_all("reset");
    check_tx("reset");

    // Plan frame: mask 0xF2, payload 0x37, checksum 0xC5.
    fill_frame(8'hF2, 8'h37, 8'h37);
    chk("plan_cks", frm[19], 8'hC5);
    send_frame("frameA");

    // Attenuation and phase overrides, including the exact 3-cycle latency.
    @(negedge clk); a31 = 1'b1; p180 = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("attn_lat2", attn_o[0], 6'h37);
    @(negedge clk);
    chk("attn_lat3", attn_o[0], 6'h3F);
    chk("phase_lat3", phase_o[0], 6'h17);
    check_all("ovr");
    a31 = 1'b0; p180 = 1'b0;
    repeat (4) @(negedge clk);

    // Inhibit masks power and the T/R pulse.
    inh = 1'b1; trp = 1'b1;
    repeat (4) @(negedge clk);
    check_all("inhibit");
    inh = 1'b0;
    repeat (4) @(negedge clk);
    check_all("tr_on");
    trp = 1'b0;
    repeat (4) @(negedge clk);
    trp = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("tr_lat2", tro, 1'b0);
    @(negedge clk);
    chk("tr_lat3", tro, 1'b1);
    trp = 1'b0;
    repeat (4) @(negedge clk);

    // Bad checksum, with a payload that differs from the committed one.
    fill_frame(8'h0F, 8'h37, 8'h37);
    frm[19] = 8'hC4;
    send_frame("bad_cks");

    // Bad footer, then a valid frame whose payload contains header-valued bytes.
    fill_frame(8'h3C, 8'h21, 8'h00);
    frm[20] = 8'h54;
    send_frame("bad_footer");
    fill_frame(8'hAA, 8'hAA, 8'h01);
    send_frame("frameB");

    // A stalled partial frame must time out so that the next frame is parsed cleanly.
    send_byte(8'hAA);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    repeat (40 * BIT) @(negedge clk);
    fill_frame(8'h5A, 8'h0C, 8'h01);
    send_frame("after_timeout");

    // Reset after byte 10 of a frame, then a full valid frame.
    fill_frame(8'hC3, 8'h2B, 8'h01);
    for (int i = 0; i <= 10; i++) send_byte(frm[i]);
    @(negedge clk); rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("in_reset");
    rst = 1'b0;
    check_all("post_reset");
    fill_frame(8'hF2, 8'h37, 8'h37);
    send_frame("frame_after_rst");

    // Randomized frames and override combinations.
    for (int n = 0; n < 5; n++) begin
      int kind;
      logic [7:0] x;
      frm[0] = 8'hAA;
      for (int i = 1; i <= 18; i++) frm[i] = 8'($urandom);
      x = 8'h00;
      for (int i = 1; i <= 18; i++) x ^= frm[i];
      frm[19] = x;
      frm[20] = 8'h55;
      kind = $urandom_range(0, 3);
      if (kind == 2) frm[19] = x ^ 8'(1 << $urandom_range(0, 7));
      if (kind == 3) frm[20] = 8'h55 ^ 8'($urandom_range(1, 255));
      inh  = 1'($urandom);
      a31  = 1'($urandom);
      p180 = 1'($urandom);
      trp  = 1'($urandom);
      send_frame($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/plank_ctrl.md
# plank_ctrl

UART-programmed beam-steering controller for an 8-channel T/R plank. It receives a 21-byte command frame on a serial line and validates header, XOR checksum and footer. Valid frames update the per-channel power-enable, 6-bit attenuator and 6-bit phase-shifter registers. Hardware override inputs (31.5 dB attenuation, 180° phase, inhibit) are applied on top, and the T/R pulse is gated to the plank.

## Interface
- CLKS_PER_BIT, 868, clocks per UART bit (100 MHz / 115200 baud).
- i_clk  in  1  system clock, 100 MHz.
- i_rst  in  1  asynchronous, active-high reset.
- i_rx_serial  in  1  UART RX: 8N1, LSB first, idle high.
- i_inhibit  in  1  forces all channel power off and T/R pulse low.
- i_TR_pulse  in  1  T/R timing pulse from the radar.
- i_attn_31p5  in  1  forces every attenuator code to 6'h3F.
- i_phase_180  in  1  adds 180° (code +32, mod 64) to every phase code.
- o_tx_serial  out  1  UART TX; ACK/NAK response.
- o_ch_power  out  8  channel power enables; bit n = channel n+1.
- o_attn_ch1..o_attn_ch8  out  6 each  attenuator codes, 0.5 dB/LSB.
- o_phase_ch1..o_phase_ch8  out  6 each  phase codes, 5.625°/LSB.
- o_TR_Pulse  out  1  gated T/R pulse.
- io_scl, io_sda  inout  1 each  reserved I2C bus; always released (high-Z).

## Operation
- RX front end:
  - i_rx_serial passes through a 2-FF synchronizer.
  - A falling edge starts a byte; the start bit is re-checked at CLKS_PER_BIT/2 and the byte is aborted if it reads high.
  - Data bits are sampled mid-bit.
  - A stop bit sampled low discards the byte.
- Frame, byte index 0..20:
  - 0 = header 0xAA
  - 1 = power mask
  - 2..9 = attn ch1..8 (bits[5:0])
  - 10..17 = phase ch1..8 (bits[5:0])
  - 18 = control (bit0 = TR enable; bits[7:1] ignored)
  - 19 = checksum, the XOR of bytes 1..18
  - 20 = footer 0x55
  - Bits[7:6] of bytes 2..17 are ignored.
- Parser FSM:
  - WAIT_HDR: stay here until a byte equal to 0xAA arrives.
  - PAYLOAD: collect 18 bytes into a shadow buffer and accumulate the XOR.
  - CHECK: compare the received checksum byte with the accumulated XOR.
  - FOOTER: expect 0x55.
- Commit rule:
  - If the checksum matches and the footer is 0x55, the shadow buffer is copied to the live registers in one cycle.
  - Otherwise the live registers are unchanged.
  - In every case the FSM returns to WAIT_HDR.
- Timeout: if no byte completes within 32 bit times while the FSM is outside WAIT_HDR, the partial frame is dropped and the FSM returns to WAIT_HDR.
- Output mapping (registered):
  - o_ch_power = i_inhibit ? 0 : power mask.
  - o_attn_chN = i_attn_31p5 ? 6'h3F : attnN.
  - o_phase_chN = phaseN + (i_phase_180 ? 32 : 0), 6-bit wrap.
  - o_TR_Pulse = i_TR_pulse & TR enable & ~i_inhibit.
- Override inputs are asynchronous to the frame; each goes through a 2-FF synchronizer before use.

## Timing
- Reset values:
  - o_ch_power = 0
  - all o_attn = 6'h3F
  - all o_phase = 0
  - TR enable = 0
  - o_TR_Pulse = 0
  - o_tx_serial = 1
  - FSM = WAIT_HDR
  - io_scl/io_sda = Z
- Reset mid-frame discards the frame and restores the reset values.
- Commit latency: live registers update 1 cycle after the footer's stop-bit sample. The outputs follow 1 cycle later.
- Override latency: 3 cycles from an override input change to the outputs (2 synchronizer stages + 1 output register).
- o_TR_Pulse latency: 3 cycles from i_TR_pulse.
- If a commit and an override change land in the same cycle, both take effect and the output register reflects both.
- A header byte (0xAA) received inside PAYLOAD is treated as data, not as a resync.

## Configuration
- PLANK_TX_ACK_EN:
  - Defined: after each complete frame the block transmits one 8N1 byte on o_tx_serial, starting 1 cycle after the verdict. The byte is 0x06 on commit and 0x15 on a checksum or footer failure. If a new verdict arrives while a byte is still being sent, that verdict is dropped.
  - Undefined: o_tx_serial is tied to 1 and no TX logic is built.

## Test plan
- Reset, then a frame with byte1 = 0xF2, bytes 2..18 = 0x37, checksum 0xC5, footer 0x55; all overrides low:
  - o_ch_power = 0xF2
  - all attn and phase outputs = 0x37
  - ACK 0x06 on o_tx_serial (with PLANK_TX_ACK_EN)
- Same frame, then i_attn_31p5 = 1 and i_phase_180 = 1:
  - all attn outputs = 0x3F
  - all phase outputs = 0x17
- Same frame, then i_inhibit = 1 and i_TR_pulse = 1:
  - o_ch_power = 0 and o_TR_Pulse = 0
  - with i_inhibit = 0, o_TR_Pulse = 1 three cycles after i_TR_pulse rises
- Frame with checksum 0xC4: outputs keep their previous values and NAK 0x15 is sent.
- Valid frame with footer 0x54: rejected. The next valid frame is accepted.
- Assert i_rst after byte 10 of a frame, then release it and send a full valid frame: outputs return to reset values, then update normally from the new frame.
